recon_io_v2: RTL

RECON_IO_V2 -- requirements
Module: recon_io_v2

---
 rtl/recon_io_v2.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/recon_io_v2.sv
// Reconfigurable GPIO block: Avalon-MM register file, debounced inputs,
// edge/level interrupts and per-pin PWM with a shared prescaled counter.
module recon_io_v2 #(
   parameter int PORT_WIDTH     = 16,
   parameter int PWM_CNTR_WIDTH = 8,
   parameter int DBNC_WIDTH     = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [5:0]            address,
   input  logic                  chipselect,
   input  logic                  write,
   input  logic                  read,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic                  irq,
   input  logic [PORT_WIDTH-1:0] io_in,
   output logic [PORT_WIDTH-1:0] io_out,
   output logic [PORT_WIDTH-1:0] io_oe,
   output logic [PORT_WIDTH-1:0] io_opdrn
);

   localparam int PW = PORT_WIDTH;
   localparam int CW = PWM_CNTR_WIDTH;
   localparam int DW = DBNC_WIDTH;

   logic          wr_en;
   logic          rd_en;
   logic [PW-1:0] wd;

   logic [PW-1:0] dir_r;
   logic [PW-1:0] out_r;
   logic [PW-1:0] opendrn_r;
   logic [PW-1:0] pwm_ena;
   logic [PW-1:0] irq_status;
   logic [PW-1:0] irq_ena;
   logic [PW-1:0] irq_redge;
   logic [PW-1:0] irq_fedge;
   logic [PW-1:0] dbnc_ena;
   logic [PW-1:0] irq_level;
   logic [DW-1:0] dbnc_time;
   logic [CW-1:0] pwm_period;
   logic [15:0]   pwm_prescale;
   logic [CW-1:0] pwm_duty [PW];

   logic [PW-1:0] sync1;
   logic [PW-1:0] sync2;
   logic [PW-1:0] filtered;
   logic [PW-1:0] filtered_d;
   logic [DW-1:0] dbnc_cnt [PW];

   logic [PW-1:0] events;
   logic [PW-1:0] w1c;

   logic [15:0]   pre_cnt;
   logic [CW-1:0] pwm_cntr;
   logic          tick;
   logic          cnt_restart;
   logic [PW-1:0] pwm_out;

   logic [31:0]   rd_mux;
   logic          unused_wd;

   assign wr_en     = chipselect & write;
   assign rd_en     = chipselect & read;
   assign wd        = writedata[PW-1:0];
   assign unused_wd = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir_r        <= '0;
         out_r        <= '0;
         opendrn_r    <= '0;
         pwm_ena      <= '0;
         irq_ena      <= '0;
         irq_redge    <= '0;
         irq_fedge    <= '0;
         dbnc_ena     <= '0;
         irq_level    <= '0;
         dbnc_time    <= '0;
         pwm_period   <= '1;
         pwm_prescale <= '0;
         for (int i = 0; i < PW; i++) pwm_duty[i] <= '0;
      end else if (wr_en) begin
         case (address)
            6'd0:  dir_r        <= wd;
            6'd1:  out_r        <= wd;
            6'd3:  out_r        <= out_r | wd;
            6'd4:  out_r        <= out_r & ~wd;
            6'd5:  opendrn_r    <= wd;
            6'd6:  pwm_ena      <= wd;
            6'd8:  irq_ena      <= wd;
            6'd9:  irq_redge    <= wd;
            6'd10: irq_fedge    <= wd;
            6'd11: dbnc_ena     <= wd;
            6'd12: dbnc_time    <= writedata[DW-1:0];
            6'd13: pwm_period   <= writedata[CW-1:0];
            6'd14: pwm_prescale <= writedata[15:0];
            6'd15: irq_level    <= wd;
            default: begin
               for (int i = 0; i < PW; i++)
                  if (address == 6'(16 + i))
                     pwm_duty[i] <= writedata[CW-1:0];
            end
         endcase
      end
   end

   // Debounce: a pin must disagree with its filtered value for
   // dbnc_time+1 consecutive cycles before the filtered value flips.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1      <= '0;
         sync2      <= '0;
         filtered   <= '0;
         filtered_d <= '0;
         for (int i = 0; i < PW; i++) dbnc_cnt[i] <= '0;
      end else begin
         sync1      <= io_in;
         sync2      <= sync1;
         filtered_d <= filtered;
         for (int i = 0; i < PW; i++) begin
            if (!dbnc_ena[i]) begin
               filtered[i] <= sync2[i];
               dbnc_cnt[i] <= '0;
            end else if (sync2[i] == filtered[i]) begin
               dbnc_cnt[i] <= '0;
            end else if (dbnc_cnt[i] == dbnc_time) begin
               filtered[i] <= sync2[i];
               dbnc_cnt[i] <= '0;
            end else begin
               dbnc_cnt[i] <= dbnc_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign events = (filtered & ~filtered_d & irq_redge)
                 | (~filtered & filtered_d & irq_fedge);
   assign w1c    = (wr_en && address == 6'd7) ? wd : '0;

   // Edge-mode bits: a new event outranks a coincident clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_status <= '0;
      end else begin
         irq_status <= (irq_level & filtered & irq_ena)
                     | (~irq_level & ((irq_status & ~w1c)
                                    | (events & irq_ena)));
      end
   end

   assign irq         = |irq_status;
   assign tick        = (pre_cnt == pwm_prescale);
   assign cnt_restart = wr_en && (address == 6'd13 || address == 6'd14);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt  <= '0;
         pwm_cntr <= '0;
         pwm_out  <= '0;
      end else begin
         if (cnt_restart) begin
            pre_cnt  <= '0;
            pwm_cntr <= '0;
         end else if (tick) begin
            pre_cnt  <= '0;
            pwm_cntr <= (pwm_cntr == pwm_period) ? '0 : pwm_cntr + CW'(1);
         end else begin
            pre_cnt  <= pre_cnt + 16'd1;
         end
         for (int i = 0; i < PW; i++)
            pwm_out[i] <= pwm_ena[i] & (pwm_cntr < pwm_duty[i]);
      end
   end

   assign io_oe    = dir_r | pwm_ena;
   assign io_out   = (pwm_ena & pwm_out) | (~pwm_ena & out_r);
   assign io_opdrn = opendrn_r;

   always_comb begin
      rd_mux = '0;
      case (address)
         6'd0:  rd_mux = 32'(dir_r);
         6'd1:  rd_mux = 32'(out_r);
         6'd2:  rd_mux = 32'(filtered);
         6'd5:  rd_mux = 32'(opendrn_r);
         6'd6:  rd_mux = 32'(pwm_ena);
         6'd7:  rd_mux = 32'(irq_status);
         6'd8:  rd_mux = 32'(irq_ena);
         6'd9:  rd_mux = 32'(irq_redge);
         6'd10: rd_mux = 32'(irq_fedge);
         6'd11: rd_mux = 32'(dbnc_ena);
         6'd12: rd_mux = 32'(dbnc_time);
         6'd13: rd_mux = 32'(pwm_period);
         6'd14: rd_mux = 32'(pwm_prescale);
         6'd15: rd_mux = 32'(irq_level);
         default: begin
            for (int i = 0; i < PW; i++)
               if (address == 6'(16 + i))
                  rd_mux = 32'(pwm_duty[i]);
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else if (rd_en) readdata <= rd_mux;
   end

endmodule
